writeback: RTL and testbench

- Final ARM pipeline stage. Retires results produced by execute/memory into the register file and CPSR.
- Serialises dual-destination instructions (load/ALU result plus base writeback) onto the single regfile write port, stalling the memory stage while it does so.
- Publishes per-cycle retire masks so the issue-side scoreboard knows which definitions have landed.
- Turns writes to r15 into a PC redirect.

---
 rtl/writeback.sv | 206 ++++++++++++++++++++
 tb/tb_writeback.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
//
// Final ARM pipeline stage. It commits execute/memory results to the register
// file and the CPSR. An instruction can carry two register results (load or
// ALU data plus a base writeback). The register file has one write port, so the
// second result is written one cycle later and the memory stage is stalled for
// that cycle.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   inbubble       the input slot is empty this cycle
//   inpc, insn     PC and opcode of the incoming instruction (trace only)
//   in_wr*         primary write (load data or ALU result)
//   in_wr2*        secondary write (base writeback)
//   in_cpsrwr      CPSR update valid; in_cpsr is the new value
//   outstall       upstream must hold its outputs
//   rf_we/num/data register file write port
//   cpsr           architectural CPSR
//   retire_regs    one-hot of the register written this cycle (r15 excluded)
//   retire_cpsr    the CPSR was written this cycle
//   jmp, jmppc     r15 was written: fetch redirect and upstream flush
//
// Every output is a flop. A write appears one cycle after its input is
// accepted.
// -----------------------------------------------------------------------------
module writeback #(
    parameter logic [31:0] CPSR_RESET = 32'h000000D3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inbubble,
    input  logic [31:0] inpc,
    input  logic [31:0] insn,
    input  logic        in_wr,
    input  logic [3:0]  in_wrnum,
    input  logic [31:0] in_wrdata,
    input  logic        in_wr2,
    input  logic [3:0]  in_wr2num,
    input  logic [31:0] in_wr2data,
    input  logic        in_cpsrwr,
    input  logic [31:0] in_cpsr,
    output logic        outstall,
    output logic        rf_we,
    output logic [3:0]  rf_num,
    output logic [31:0] rf_data,
    output logic [31:0] cpsr,
    output logic [15:0] retire_regs,
    output logic        retire_cpsr,
    output logic        jmp,
    output logic [31:0] jmppc
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_hold_num;
    logic [31:0] r_hold_data;

    logic        w_accept;
    logic        w_we;
    logic [3:0]  w_num;
    logic [31:0] w_data;
    logic        w_cpsr_we;
    logic        w_hold_load;

    // PC and opcode are carried for trace hooks only. They do not affect
    // architectural state.
    logic        w_unused_trace;
    assign w_unused_trace = ^{inpc, insn};

    // The input slot is only consumed in IDLE. In DRAIN, upstream is stalled
    // and re-presents the same instruction, so those inputs must be ignored.
    assign w_accept = (r_state == S_IDLE) && !inbubble;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: each variable driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Serialise only when both writes target different registers.
                // When they match, the primary result wins and the base
                // writeback is dropped.
                if (w_accept && in_wr && in_wr2 && (in_wr2num != in_wrnum)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_we        = 1'b0;
        w_num       = rf_num;
        w_data      = rf_data;
        w_cpsr_we   = 1'b0;
        w_hold_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (in_wr) begin
                        w_we   = 1'b1;
                        w_num  = in_wrnum;
                        w_data = in_wrdata;
                    end else if (in_wr2) begin
                        w_we   = 1'b1;
                        w_num  = in_wr2num;
                        w_data = in_wr2data;
                    end
                    // The CPSR is written with the first register write only.
                    // DRAIN never touches it.
                    w_cpsr_we   = in_cpsrwr;
                    w_hold_load = (w_state_next == S_DRAIN);
                end
            end
            S_DRAIN: begin
                w_we   = 1'b1;
                w_num  = r_hold_num;
                w_data = r_hold_data;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs and the secondary-write hold registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstall    <= 1'b0;
            rf_we       <= 1'b0;
            rf_num      <= 4'd0;
            rf_data     <= 32'd0;
            cpsr        <= CPSR_RESET;
            retire_regs <= 16'd0;
            retire_cpsr <= 1'b0;
            jmp         <= 1'b0;
            jmppc       <= 32'd0;
            r_hold_num  <= 4'd0;
            r_hold_data <= 32'd0;
        end else begin
            // The stall is high for exactly the cycle spent in DRAIN.
            outstall    <= (w_state_next == S_DRAIN);
            rf_we       <= w_we;
            rf_num      <= w_num;
            rf_data     <= w_data;
            retire_cpsr <= w_cpsr_we;
            if (w_cpsr_we) begin
                cpsr <= in_cpsr;
            end

            // r15 retires through the redirect, not through the scoreboard mask.
            if (w_we && (w_num != 4'd15)) begin
                retire_regs <= 16'd1 << w_num;
            end else begin
                retire_regs <= 16'd0;
            end

            // The r15 register write still happens. jmp pulses with it. A
            // pending DRAIN still completes after the redirect, because the
            // flush only clears instructions younger than this one.
            jmp <= w_we && (w_num == 4'd15);
            if (w_we && (w_num == 4'd15)) begin
                jmppc <= w_data;
            end

            if (w_hold_load) begin
                r_hold_num  <= in_wr2num;
                r_hold_data <= in_wr2data;
            end
        end
    end

endmodule

// File: tb/tb_writeback.sv
// -----------------------------------------------------------------------------
// tb_writeback
//
// Directed bench for writeback. It drives inputs 1 time unit after a rising
// edge. It samples outputs 1 time unit after the next rising edge. Every
// expected value below is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_writeback;

    logic        clk;
    logic        rst;
    logic        inbubble;
    logic [31:0] inpc;
    logic [31:0] insn;
    logic        in_wr;
    logic [3:0]  in_wrnum;
    logic [31:0] in_wrdata;
    logic        in_wr2;
    logic [3:0]  in_wr2num;
    logic [31:0] in_wr2data;
    logic        in_cpsrwr;
    logic [31:0] in_cpsr;
    logic        outstall;
    logic        rf_we;
    logic [3:0]  rf_num;
    logic [31:0] rf_data;
    logic [31:0] cpsr;
    logic [15:0] retire_regs;
    logic        retire_cpsr;
    logic        jmp;
    logic [31:0] jmppc;

    int checks   = 0;
    int failures = 0;

    writeback dut (
        .clk         (clk),
        .rst         (rst),
        .inbubble    (inbubble),
        .inpc        (inpc),
        .insn        (insn),
        .in_wr       (in_wr),
        .in_wrnum    (in_wrnum),
        .in_wrdata   (in_wrdata),
        .in_wr2      (in_wr2),
        .in_wr2num   (in_wr2num),
        .in_wr2data  (in_wr2data),
        .in_cpsrwr   (in_cpsrwr),
        .in_cpsr     (in_cpsr),
        .outstall    (outstall),
        .rf_we       (rf_we),
        .rf_num      (rf_num),
        .rf_data     (rf_data),
        .cpsr        (cpsr),
        .retire_regs (retire_regs),
        .retire_cpsr (retire_cpsr),
        .jmp         (jmp),
        .jmppc       (jmppc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction slot. The DUT sees it at the next rising edge.
    task automatic drive(input logic bub,
                         input logic wr,  input logic [3:0] wn,  input logic [31:0] wd,
                         input logic wr2, input logic [3:0] wn2, input logic [31:0] wd2,
                         input logic cw,  input logic [31:0] cv);
        inbubble   = bub;
        in_wr      = wr;
        in_wrnum   = wn;
        in_wrdata  = wd;
        in_wr2     = wr2;
        in_wr2num  = wn2;
        in_wr2data = wd2;
        in_cpsrwr  = cw;
        in_cpsr    = cv;
        inpc       = inpc + 32'd4;
        insn       = 32'hE1A00000;
    endtask

    task automatic bubble();
        drive(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        inpc = 32'h0;
        bubble();
        #2;
        // Reset state, sampled while reset is held
        check("rst_rf_we",    32'(rf_we),       32'd0);
        check("rst_outstall", 32'(outstall),    32'd0);
        check("rst_cpsr",     cpsr,             32'h000000D3);
        check("rst_retire",   32'(retire_regs), 32'd0);
        check("rst_jmp",      32'(jmp),         32'd0);
        tick();
        rst = 1'b0;

        // Single write: r3 = 0x1234
        drive(1'b0, 1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        tick();
        check("single_we",       32'(rf_we),       32'd1);
        check("single_num",      32'(rf_num),      32'd3);
        check("single_data",     rf_data,          32'h1234);
        check("single_retire",   32'(retire_regs), 32'h0008);
        check("single_outstall", 32'(outstall),    32'd0);

        // Dual write: r0 = 0xAAAA then r4 = 0x1004
        drive(1'b0, 1'b1, 4'd0, 32'hAAAA, 1'b1, 4'd4, 32'h1004, 1'b0, 32'd0);
        tick();
        check("dual1_num",      32'(rf_num),      32'd0);
        check("dual1_data",     rf_data,          32'hAAAA);
        check("dual1_retire",   32'(retire_regs), 32'h0001);
        check("dual1_outstall", 32'(outstall),    32'd1);
        // The next instruction (r6 = 0x66) waits upstream during DRAIN and
        // must not be taken at this edge.
        drive(1'b0, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        tick();
        check("dual2_we",       32'(rf_we),       32'd1);
        check("dual2_num",      32'(rf_num),      32'd4);
        check("dual2_data",     rf_data,          32'h1004);
        check("dual2_retire",   32'(retire_regs), 32'h0010);
        check("dual2_outstall", 32'(outstall),    32'd0);
        tick();
        check("held_num",    32'(rf_num),      32'd6);
        check("held_data",   rf_data,          32'h66);
        check("held_retire", 32'(retire_regs), 32'h0040);

        // Secondary only: r7 = 0x77, no stall
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h77, 1'b0, 32'd0);
        tick();
        check("wr2only_num",      32'(rf_num),   32'd7);
        check("wr2only_data",     rf_data,       32'h77);
        check("wr2only_outstall", 32'(outstall), 32'd0);

        // Same-register collision: the primary value wins
        drive(1'b0, 1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2, 1'b0, 32'd0);
        tick();
        check("coll_num",      32'(rf_num),   32'd5);
        check("coll_data",     rf_data,       32'h1);
        check("coll_outstall", 32'(outstall), 32'd0);
        bubble();
        tick();
        check("coll_no_second", 32'(rf_we), 32'd0);

        // r15 write with a CPSR update
        drive(1'b0, 1'b1, 4'd15, 32'h8000, 1'b0, 4'd0, 32'd0, 1'b1, 32'h6000001F);
        tick();
        check("r15_we",          32'(rf_we),       32'd1);
        check("r15_num",         32'(rf_num),      32'd15);
        check("r15_jmp",         32'(jmp),         32'd1);
        check("r15_jmppc",       jmppc,            32'h8000);
        check("r15_retire",      32'(retire_regs), 32'd0);
        check("r15_retire_cpsr", 32'(retire_cpsr), 32'd1);
        check("r15_cpsr",        cpsr,             32'h6000001F);
        bubble();
        tick();
        check("r15_jmp_pulse",  32'(jmp),         32'd0);
        check("r15_rcpsr_drop", 32'(retire_cpsr), 32'd0);

        // Bubble with every write valid high
        drive(1'b1, 1'b1, 4'd2, 32'hDEAD, 1'b1, 4'd9, 32'hBEEF, 1'b1, 32'hFFFFFFFF);
        tick();
        check("bub_we",          32'(rf_we),       32'd0);
        check("bub_retire",      32'(retire_regs), 32'd0);
        check("bub_retire_cpsr", 32'(retire_cpsr), 32'd0);
        check("bub_cpsr",        cpsr,             32'h6000001F);
        check("bub_outstall",    32'(outstall),    32'd0);

        // Reset asserted mid-DRAIN drops the pending r2 write
        drive(1'b0, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0, 32'd0);
        tick();
        check("rdrain_num",      32'(rf_num),   32'd1);
        check("rdrain_outstall", 32'(outstall), 32'd1);
        bubble();
        #2;
        rst = 1'b1;
        #1;
        check("rdrain_async_we",       32'(rf_we),    32'd0);
        check("rdrain_async_num",      32'(rf_num),   32'd0);
        check("rdrain_async_data",     rf_data,       32'd0);
        check("rdrain_async_outstall", 32'(outstall), 32'd0);
        check("rdrain_async_cpsr",     cpsr,          32'h000000D3);
        tick();
        rst = 1'b0;
        tick();
        check("rdrain_no_r2_we",  32'(rf_we),       32'd0);
        check("rdrain_no_r2_ret", 32'(retire_regs), 32'd0);
        tick();
        check("rdrain_idle_we",   32'(rf_we),       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
